// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the SPI master slice.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spi_master_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_if
//  Purpose  : Controller handshake plus SPI pins of the byte-oriented master.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) ();

    logic              master_start;
    logic [DATA_W-1:0] master_data_trans;
    logic              master_miso;
    logic              master_sck;
    logic              master_ss;
    logic              master_mosi;
    logic              master_busy;
    logic              master_done;
    logic [DATA_W-1:0] master_data_rec;

    modport master (
        input  master_start,
        input  master_data_trans,
        input  master_miso,
        output master_sck,
        output master_ss,
        output master_mosi,
        output master_busy,
        output master_done,
        output master_data_rec
    );

    modport slave (
        output master_start,
        output master_data_trans,
        output master_miso,
        input  master_sck,
        input  master_ss,
        input  master_mosi,
        input  master_busy,
        input  master_done,
        input  master_data_rec
    );

endinterface
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : spi_clk_div
//  Purpose  : Phase timer; o_tick marks the last cycle of each CLK_DIV phase.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam int                 c_CNT_W = cnt_width(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Held at zero while disabled so every enable starts a fresh phase.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : Byte SPI master: preamble pulse, DATA_W data pulses, trailer.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int PRE_PULSES  = 1,
    parameter int POST_PULSES = 1
) (
    input  wire logic      master_clk,
    input  wire logic      master_reset,
    spi_master_if.master   bus
);

    localparam int                c_TOTAL      = PRE_PULSES + DATA_W + POST_PULSES;
    localparam int                c_PC_W       = cnt_width(c_TOTAL);
    localparam logic [c_PC_W-1:0] c_LAST_PULSE = c_PC_W'(c_TOTAL - 1);

    spi_master_state_t r_state;
    logic              r_sck;
    logic              r_ss;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_data_rec;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [c_PC_W-1:0] r_pulse_cnt;

    logic w_tick;
    logic w_en;
    logic w_cur_data;
    logic w_next_data;

    assign w_en = (r_state != IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (master_clk),
        .rst    (master_reset),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    assign w_cur_data  = (int'(r_pulse_cnt) >= PRE_PULSES) &&
                         (int'(r_pulse_cnt) <  PRE_PULSES + DATA_W);
    assign w_next_data = (int'(r_pulse_cnt) + 1 >= PRE_PULSES) &&
                         (int'(r_pulse_cnt) + 1 <  PRE_PULSES + DATA_W);

    always_ff @(posedge master_clk) begin
        if (master_reset) begin
            r_state     <= IDLE;
            r_sck       <= 1'b0;
            r_ss        <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_data_rec  <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_pulse_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pulse_cnt <= '0;
                    if (bus.master_start) begin
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rx_sr <= '0;
                        r_state <= SETUP;
                        // Without a preamble the first data bit must be on mosi already.
                        if (PRE_PULSES == 0) begin
                            r_mosi  <= bus.master_data_trans[DATA_W-1];
                            r_tx_sr <= bus.master_data_trans << 1;
                        end else begin
                            r_mosi  <= 1'b0;
                            r_tx_sr <= bus.master_data_trans;
                        end
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_tick) begin
                        r_sck <= 1'b0;
                        if (w_cur_data) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], bus.master_miso};
                        end
                        if (w_next_data) begin
                            r_mosi  <= r_tx_sr[DATA_W-1];
                            r_tx_sr <= r_tx_sr << 1;
                        end else begin
                            r_mosi  <= 1'b0;
                        end
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_tick) begin
                        if (r_pulse_cnt != c_LAST_PULSE) begin
                            r_pulse_cnt <= r_pulse_cnt + c_PC_W'(1);
                            r_sck       <= 1'b1;
                            r_state     <= HIGH;
                        end else begin
                            r_ss    <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_done     <= 1'b1;
                        r_data_rec <= r_rx_sr;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.master_sck      = r_sck;
    assign bus.master_ss       = r_ss;
    assign bus.master_mosi     = r_mosi;
    assign bus.master_busy     = r_busy;
    assign bus.master_done     = r_done;
    assign bus.master_data_rec = r_data_rec;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Directed self-checking bench for spi_master (CLK_DIV 4 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   miso_mode;

    spi_master_if #(.DATA_W(8)) bus  ();
    spi_master_if #(.DATA_W(8)) fbus ();

    spi_master #(.CLK_DIV(4)) u_dut (
        .master_clk   (clk),
        .master_reset (rst),
        .bus          (bus)
    );

    spi_master #(.CLK_DIV(1)) u_dut_fast (
        .master_clk   (clk),
        .master_reset (rst),
        .bus          (fbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: loads TX on the preamble, shifts on data pulses, commits on trailer.
    logic [7:0] slave_tx_byte;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    logic [7:0] slave_rec;
    logic       s_miso;
    int         s_cnt;

    initial begin
        s_cnt = 0; s_miso = 1'b0; s_tx = '0; s_rx = '0; slave_rec = '0;
        slave_tx_byte = 8'h3C;
    end

    always @(posedge bus.master_ss) s_cnt = 0;

    always @(posedge bus.master_sck) begin
        if (!bus.master_ss) begin
            if (s_cnt == 0) begin
                s_tx = slave_tx_byte;
            end else if (s_cnt <= 8) begin
                s_rx   = {s_rx[6:0], bus.master_mosi};
                s_miso = s_tx[7];
                s_tx   = s_tx << 1;
            end else begin
                slave_rec = s_rx;
            end
            s_cnt++;
        end
    end

    assign bus.master_miso  = (miso_mode == 0) ? bus.master_mosi : s_miso;
    assign fbus.master_miso = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launches one frame on the CLK_DIV=4 master; n is the edge index after acceptance.
    task automatic run_frame(input logic [7:0] d, input bit noisy,
                             output int done_at, output logic [9:0] bits, output int pulses);
        logic prev_sck;
        bus.master_start      = 1'b1;
        bus.master_data_trans = d;
        done_at  = -1;
        pulses   = 0;
        bits     = '0;
        prev_sck = 1'b0;
        for (int n = 0; n < 200 && done_at < 0; n++) begin
            @(negedge clk);
            bus.master_start      = noisy && ((n + 1 == 5) || (n + 1 == 40) || (n + 1 == 88));
            bus.master_data_trans = ~d;
            if (bus.master_sck && !prev_sck) begin
                bits = {bits[8:0], bus.master_mosi};
                pulses++;
            end
            prev_sck = bus.master_sck;
            if (bus.master_done) done_at = n;
        end
        bus.master_start = 1'b0;
    endtask

    task automatic idle_watch(input int cycles, output int dones, output int busies);
        dones  = 0;
        busies = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (bus.master_done) dones++;
            if (bus.master_busy) busies++;
        end
    endtask

    initial begin
        int         done_at;
        int         pulses;
        int         dones;
        int         busies;
        logic [9:0] bits;
        int         d1, d2, gap;
        logic [7:0] rec1, rec2;

        n_checks = 0;
        n_errors = 0;
        miso_mode = 0;
        rst = 1'b1;
        bus.master_start = 1'b0;  bus.master_data_trans = '0;
        fbus.master_start = 1'b0; fbus.master_data_trans = '0;
        repeat (3) @(negedge clk);

        check("rst_ss",       32'(bus.master_ss),       1);
        check("rst_sck",      32'(bus.master_sck),      0);
        check("rst_mosi",     32'(bus.master_mosi),     0);
        check("rst_busy",     32'(bus.master_busy),     0);
        check("rst_done",     32'(bus.master_done),     0);
        check("rst_data_rec", 32'(bus.master_data_rec), 0);
        rst = 1'b0;
        @(negedge clk);

        // Loopback 0xA5: preamble 0, data bits, trailer 0.
        run_frame(8'hA5, 1'b0, done_at, bits, pulses);
        check("lb_done_at",  32'(done_at), 88);
        check("lb_pulses",   32'(pulses),  10);
        check("lb_mosi",     32'(bits),    32'h14A);
        check("lb_data_rec", 32'(bus.master_data_rec), 32'hA5);
        check("lb_busy",     32'(bus.master_busy), 0);
        idle_watch(10, dones, busies);
        check("lb_done_once", 32'(dones), 0);

        // Paired with the slave model.
        miso_mode = 1;
        run_frame(8'hC3, 1'b0, done_at, bits, pulses);
        check("sl_done_at",   32'(done_at), 88);
        check("sl_master_rec", 32'(bus.master_data_rec), 32'h3C);
        check("sl_slave_rec",  32'(slave_rec), 32'hC3);
        idle_watch(5, dones, busies);

        // Starts at edges 5, 40 and the done edge are ignored; late data changes too.
        miso_mode = 0;
        run_frame(8'h5A, 1'b1, done_at, bits, pulses);
        check("ign_done_at",  32'(done_at), 88);
        check("ign_data_rec", 32'(bus.master_data_rec), 32'h5A);
        check("ign_pulses",   32'(pulses), 10);
        idle_watch(120, dones, busies);
        check("ign_extra_done", 32'(dones),  0);
        check("ign_extra_busy", 32'(busies), 0);

        // Reset at edge 30 of a frame.
        bus.master_start = 1'b1;
        bus.master_data_trans = 8'h33;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            bus.master_start = 1'b0;
            if (n == 29) rst = 1'b1;
        end
        @(negedge clk);
        check("mid_ss",       32'(bus.master_ss),       1);
        check("mid_sck",      32'(bus.master_sck),      0);
        check("mid_mosi",     32'(bus.master_mosi),     0);
        check("mid_busy",     32'(bus.master_busy),     0);
        check("mid_done",     32'(bus.master_done),     0);
        check("mid_data_rec", 32'(bus.master_data_rec), 0);
        rst = 1'b0;
        idle_watch(120, dones, busies);
        check("mid_no_done", 32'(dones),  0);
        check("mid_no_busy", 32'(busies), 0);

        // Start coincident with reset.
        rst = 1'b1;
        bus.master_start = 1'b1;
        bus.master_data_trans = 8'h81;
        @(negedge clk);
        check("sr_busy", 32'(bus.master_busy), 0);
        check("sr_ss",   32'(bus.master_ss),   1);
        rst = 1'b0;
        bus.master_start = 1'b0;
        idle_watch(20, dones, busies);
        check("sr_stay_idle", 32'(busies), 0);

        // CLK_DIV=1 back-to-back frames, miso tied high.
        fbus.master_start = 1'b1;
        fbus.master_data_trans = 8'h00;
        d1 = -1; d2 = -1; gap = 0; rec1 = '0; rec2 = '0;
        for (int n = 0; n < 100 && d2 < 0; n++) begin
            @(negedge clk);
            fbus.master_start = 1'b0;
            if (fbus.master_ss && n > 0) gap++;
            if (fbus.master_done) begin
                if (d1 < 0) begin
                    d1 = n;
                    rec1 = fbus.master_data_rec;
                    fbus.master_start = 1'b1;
                    fbus.master_data_trans = 8'hFF;
                end else begin
                    d2 = n;
                    rec2 = fbus.master_data_rec;
                end
            end
        end
        fbus.master_start = 1'b0;
        check("fast_done1", 32'(d1),   22);
        check("fast_done2", 32'(d2),   45);
        check("fast_rec1",  32'(rec1), 32'hFF);
        check("fast_rec2",  32'(rec2), 32'hFF);
        check("fast_ss_gap_ge2", 32'(gap >= 2), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI master; generates the serial frame consumed by SPI_slave: sck, active-low ss, mosi; samples miso.
- Sits between the local controller (start/data handshake) and the SPI pins; one full-duplex byte per frame, MSB first.
- Frame matches the slave's framing: one preamble sck pulse lets the slave load its TX byte, then 8 data pulses, then one trailer pulse so the slave commits its received byte.

Parameters:
- CLK_DIV, 4, master_clk cycles per sck half-period (>=1)
- DATA_W, 8, frame data width
- PRE_PULSES, 1, sck pulses before the first data bit (mosi=0, miso ignored)
- POST_PULSES, 1, sck pulses after the last data bit (mosi=0, miso ignored)

Ports:
- master_clk  in  1  system clock, all logic on rising edge
- master_reset  in  1  synchronous, active-high reset
- master_start  in  1  request a frame; honoured only in IDLE
- master_data_trans  in  DATA_W  byte to send; captured when start is accepted
- master_miso  in  1  serial data from slave
- master_sck  out  1  serial clock, idle low
- master_ss  out  1  slave select, active low
- master_mosi  out  1  serial data to slave
- master_busy  out  1  high while a frame is in progress
- master_done  out  1  one-cycle pulse at frame end
- master_data_rec  out  DATA_W  last received byte, held until the next done

Behaviour:
- Reset (synchronous, active-high, wins over everything): sck=0, ss=1, mosi=0, busy=0, done=0, data_rec=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame. No done pulse; data_rec is cleared.
- Timing base: div_cnt counts 0..CLK_DIV-1. tick = (div_cnt==CLK_DIV-1). Each phase below lasts exactly CLK_DIV cycles. div_cnt clears on leaving IDLE.
- TOTAL = PRE_PULSES + DATA_W + POST_PULSES. pulse_cnt ranges 0..TOTAL-1. Data pulse i (i=0..DATA_W-1) is pulse PRE_PULSES+i.
- IDLE: busy=0. On start=1:
  - tx_sr <= data_trans
  - ss <= 0, mosi <= 0, busy <= 1
  - go to SETUP
- SETUP: sck low, ss low. On tick go to HIGH and set sck <= 1.
- HIGH: on tick:
  - sck <= 0
  - If the current pulse is data pulse i: rx_sr <= {rx_sr[DATA_W-2:0], miso}, taken on this falling edge.
  - mosi <= bit for the next pulse: tx_sr MSB if the next pulse is a data pulse, else 0. tx_sr shifts left after each data bit is presented.
  - Go to LOW.
- LOW: on tick:
  - If pulse_cnt < TOTAL-1: pulse_cnt++, sck <= 1, go to HIGH.
  - Else: ss <= 1, mosi <= 0, go to HOLD.
- HOLD: ss high, sck low. On tick:
  - done <= 1 for one cycle
  - data_rec <= rx_sr
  - busy <= 0
  - go to IDLE
- mosi is always stable across each sck rising edge (the slave samples on rising). miso is sampled CLK_DIV cycles after the slave's rising-edge update.
- Latency: the done cycle is exactly CLK_DIV*(2*TOTAL+2) cycles after the start-accept edge. Defaults: 4*22 = 88.
- start while busy or during the done cycle is ignored; no queuing.
- master_data_trans changes after acceptance have no effect on the current frame.
- Back-to-back frames: start in the cycle after done is accepted; ss is high for at least CLK_DIV+1 cycles between frames.
- CLK_DIV=1: every phase lasts one cycle; sck period is 2 master_clk cycles.

Decomposition:
- Package spi_pkg holds:
  - enum spi_master_state_t {IDLE, SETUP, HIGH, LOW, HOLD}
  - localparam SPI_DATA_W = 8
- One sub-module, spi_clk_div, generates the tick pulse:
  - Inputs: clk, synchronous reset, enable.
  - Output: tick.
  - Parameter: CLK_DIV.
  - Restarts from 0 when enable rises.

Test Plan:
- Reset mid-frame (assert at cycle 30) -> next cycle ss=1, sck=0, mosi=0, busy=0; no done; data_rec=0.
- Defaults, loopback miso=mosi, start with 0xA5 -> 10 sck pulses; mosi at rising edges of pulses 1..8 = 1,0,1,0,0,1,0,1; done at cycle 88; data_rec=0xA5.
- Paired with SPI_slave (slave_data_trans=0x3C), master sends 0xC3 -> master_data_rec=0x3C; slave_data_rec=0xC3 after the trailer pulse.
- start pulses at cycles 5, 40 and on the done cycle during a frame -> all ignored. Exactly one frame, one done.
- CLK_DIV=1, back-to-back starts with 0x00 then 0xFF, miso tied 1 -> done at 22 and 45; data_rec=0xFF both times; ss high between frames >=2 cycles.
- Start and reset asserted in the same cycle -> reset wins; stays IDLE; busy=0.
